seq_multiplier_n: RTL and testbench
===================================

SEQ_MULTIPLIER_N -- requirements
Module: seq_multiplier_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 4..32).
REQ-002 SHALL have port Clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port Reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port Start, input, 1, request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port Signed_Mode, input, 1; 1 = two's-complement operands, 0 = unsigned. Sampled with Start.
REQ-006 SHALL have port Multiplicand, input, WIDTH, operand S; sampled with Start.
REQ-007 SHALL have port Multiplier, input, WIDTH, operand M; sampled with Start.
REQ-008 SHALL have port Busy, output, 1; high in every state except IDLE.
REQ-009 SHALL have port Done, output, 1; single-cycle pulse marking a valid Product.
REQ-010 SHALL have port Product, output, 2*WIDTH, result {A,B}.
REQ-011 SHALL have port Xval, output, 1, extension bit above register A.

Function
REQ-012 SHALL hold internal registers X (1b), A (WIDTH), B (WIDTH), S (WIDTH), mode (1b) and a bit counter of $clog2(WIDTH) bits.
REQ-013 SHALL implement FSM states IDLE, ADD, SHIFT and DONE.
REQ-014 IDLE with Start=1: SHALL load B<=Multiplier, S<=Multiplicand and mode<=Signed_Mode, clear X, A and the counter, then go to ADD.
REQ-015 IDLE with Start=0: SHALL hold all registers.
REQ-016 ADD: if B[0]=1, SHALL load {X,A}<={X,A}+ext(S), where ext is sign-extension in signed mode and zero-extension in unsigned mode; a (WIDTH+1)-bit adder is used.
REQ-017 ADD: if B[0]=1, mode=signed and counter=WIDTH-1, SHALL subtract instead, as {X,A}+ext(~S)+1.
REQ-018 ADD: if B[0]=0, SHALL leave X and A unchanged; the next state is always SHIFT.
REQ-019 SHIFT: SHALL shift {X,A,B} right by one; A[WIDTH-1]<=X, B[WIDTH-1]<=A[0].
REQ-020 SHIFT: X SHALL be retained in signed mode and cleared in unsigned mode; the counter increments.
REQ-021 SHIFT: SHALL go to DONE when counter=WIDTH-1 before the increment, else to ADD.
REQ-022 DONE: SHALL assert Done for exactly one cycle, then go to IDLE.
REQ-023 Latency: the edge that samples Start is followed by exactly 2*WIDTH cycles in ADD/SHIFT; Done is high in the next cycle (cycle 2*WIDTH+1).
REQ-024 Product SHALL equal {A,B} at all times, be valid from the Done cycle, and hold until the next accepted Start.
REQ-025 Start SHALL be ignored while Busy=1.
REQ-026 Start held high continuously SHALL start a new multiply on the first IDLE cycle after DONE (back-to-back, one IDLE cycle between operations).
REQ-027 Operand input changes while Busy=1 SHALL NOT affect the result.
REQ-028 Edge cases: signed most-negative x most-negative SHALL produce the correct positive result; the unsigned carry out of the adder SHALL be captured in X.

Reset
REQ-029 Reset=1 SHALL immediately force state IDLE and clear X, A, B, S, mode and the counter to 0, so Busy=0, Done=0 and Product=0, regardless of clock.
REQ-030 Reset asserted mid-operation SHALL abort the operation; no Done pulse follows, and the next Start after release runs normally.

Verification (WIDTH=8 unless stated)
REQ-031 Signed: S=0xFF, M=0xFF, Start -> Done at cycle 17, Product=0x0001.
REQ-032 Signed: S=0x7F, M=0x81 -> Product=0xC0FF (-16129); S=0x80, M=0x80 -> Product=0x4000.
REQ-033 Unsigned: S=0xFF, M=0xFF -> Product=0xFE01; S=0x00, M=0xA5 -> Product=0x0000.
REQ-034 Start re-pulsed while Busy=1, and operands changed at cycle 5 -> first result unaffected; exactly one Done pulse.
REQ-035 Reset at cycle 6 of an operation -> Busy=0 and Product=0 immediately; a following unsigned 0x03*0x05 yields 0x000F.
REQ-036 WIDTH=16 with random signed and unsigned operands (at least 1000 each) -> Product matches the reference model and Done arrives at cycle 33.

Source files
------------

// File: rtl/seq_multiplier_n.sv
// seq_multiplier_n: shift-and-add multiplier that retires one multiplier bit per ADD/SHIFT pair.
// In signed mode the last partial product is subtracted, because the multiplier's MSB has negative weight.
module seq_multiplier_n #(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Signed_Mode,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product,
    output logic               Xval
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             x_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic             mode_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             busy_next_s;
    logic             done_next_s;
    logic             sub_s;
    logic [WIDTH:0]   addend_s;
    logic [WIDTH:0]   sum_s;

    // Widens an operand to the (WIDTH+1)-bit adder, sign- or zero-extended by mode.
    function automatic logic [WIDTH:0] ext_operand(input logic [WIDTH-1:0] v, input logic sgn);
        ext_operand = {sgn & v[WIDTH-1], v};
    endfunction

    // Partial-product adder; the final signed step adds the two's complement of S.
    always_comb begin
        sub_s    = 1'b0;
        addend_s = ext_operand(s_r, mode_r);
        if (mode_r && (cnt_r == CNT_LAST)) begin
            sub_s    = 1'b1;
            addend_s = ext_operand(~s_r, mode_r);
        end else begin
            sub_s    = 1'b0;
            addend_s = ext_operand(s_r, mode_r);
        end
        sum_s = {x_r, a_r} + addend_s + {{WIDTH{1'b0}}, sub_s};
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    state_next_s = ST_ADD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADD:   state_next_s = ST_SHIFT;
            ST_SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ADD;
                end
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode, looked ahead one cycle so the flags can be registered.
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
            ST_DONE: begin
                busy_next_s = 1'b1;
                done_next_s = 1'b1;
            end
            default: begin
                busy_next_s = 1'b1;
                done_next_s = 1'b0;
            end
        endcase
    end

    // Registered status flags.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            done_r <= done_next_s;
        end
    end

    // Datapath: operand capture, conditional add and the {X,A,B} right shift.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_r    <= 1'b0;
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            s_r    <= {WIDTH{1'b0}};
            mode_r <= 1'b0;
            cnt_r  <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (Start) begin
                        x_r    <= 1'b0;
                        a_r    <= {WIDTH{1'b0}};
                        b_r    <= Multiplier;
                        s_r    <= Multiplicand;
                        mode_r <= Signed_Mode;
                        cnt_r  <= {CW{1'b0}};
                    end else begin
                        x_r    <= x_r;
                        a_r    <= a_r;
                    end
                end
                ST_ADD: begin
                    if (b_r[0]) begin
                        {x_r, a_r} <= sum_s;
                    end else begin
                        x_r <= x_r;
                        a_r <= a_r;
                    end
                end
                ST_SHIFT: begin
                    // Unsigned carry has been moved into A, so X starts the next step clear.
                    x_r   <= mode_r & x_r;
                    a_r   <= {x_r, a_r[WIDTH-1:1]};
                    b_r   <= {a_r[0], b_r[WIDTH-1:1]};
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
                default: begin
                    x_r <= x_r;
                    a_r <= a_r;
                end
            endcase
        end
    end

    assign Busy    = busy_r;
    assign Done    = done_r;
    assign Product = {a_r, b_r};
    assign Xval    = x_r;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Self-checking bench for seq_multiplier_n: directed 8-bit cases, Start/operand interference,
// mid-operation reset, and a back-to-back random run on a 16-bit instance against a reference model.
module tb_seq_multiplier_n;

    logic        clk;
    logic        rst;
    logic        start8, sgn8, busy8, done8, x8;
    logic [7:0]  s8, m8;
    logic [15:0] prod8;
    logic        start16, sgn16, busy16, done16, x16;
    logic [15:0] s16, m16;
    logic [31:0] prod16;

    logic [15:0] q8[$];
    logic [31:0] q16[$];

    int checks;
    int errors;

    seq_multiplier_n #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(rst), .Start(start8), .Signed_Mode(sgn8),
        .Multiplicand(s8), .Multiplier(m8),
        .Busy(busy8), .Done(done8), .Product(prod8), .Xval(x8)
    );

    seq_multiplier_n #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset(rst), .Start(start16), .Signed_Mode(sgn16),
        .Multiplicand(s16), .Multiplier(m16),
        .Busy(busy16), .Done(done16), .Product(prod16), .Xval(x16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] s, input logic [31:0] m,
                                            input int w, input bit sgn);
        longint sa, ma, p, mask;
        sa = longint'(s);
        ma = longint'(m);
        if (sgn && s[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && m[w-1]) ma = ma - (longint'(1) << w);
        p    = sa * ma;
        mask = (longint'(1) << (2 * w)) - longint'(1);
        return 64'(p & mask);
    endfunction

    // Drives one 8-bit multiply, queues its expectation, and waits (bounded) for Done.
    task automatic do_op8(input logic [7:0] s, input logic [7:0] m, input bit sgn,
                          input logic [15:0] exp_p, output int cyc, output logic [15:0] prod);
        @(negedge clk);
        s8 = s; m8 = m; sgn8 = sgn; start8 = 1'b1;
        q8.push_back(exp_p);
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start8 = 1'b0;
        while (done8 !== 1'b1 && cyc < 64) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        prod = prod8;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0000 || x8 !== 1'b0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b prod=%h x=%b, want 0 0 0000 0", busy8, done8, prod8, x8);
        end
        checks++;
        if (busy16 !== 1'b0 || done16 !== 1'b0 || prod16 !== 32'h0 || x16 !== 1'b0) begin
            errors++;
            $display("FAIL reset16: busy=%b done=%b prod=%h x=%b, want 0 0 0 0", busy16, done16, prod16, x16);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_signed;
        logic [7:0]  ts[6];
        logic [7:0]  tm[6];
        logic [15:0] tp[6];
        logic [63:0] r;
        logic [15:0] got, exp_p;
        int cyc;
        ts[0] = 8'hFF; tm[0] = 8'hFF; tp[0] = 16'h0001;
        ts[1] = 8'h7F; tm[1] = 8'h81; tp[1] = 16'hC0FF;
        ts[2] = 8'h80; tm[2] = 8'h80; tp[2] = 16'h4000;
        ts[3] = 8'h80; tm[3] = 8'h7F; tp[3] = 16'hC080;
        ts[4] = 8'h05; tm[4] = 8'hFD; tp[4] = 16'hFFF1;
        ts[5] = 8'h00; tm[5] = 8'h80; tp[5] = 16'h0000;
        for (int i = 0; i < 26; i++) begin
            logic [7:0] s, m;
            if (i < 6) begin
                s = ts[i]; m = tm[i]; exp_p = tp[i];
            end else begin
                s = 8'($urandom); m = 8'($urandom);
                r = ref_mul({24'h0, s}, {24'h0, m}, 8, 1'b1);
                exp_p = r[15:0];
            end
            do_op8(s, m, 1'b1, exp_p, cyc, got);
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL signed_sb: scoreboard empty at op %0d", i);
            end else if (got !== q8[0]) begin
                errors++;
                $display("FAIL signed_prod: %h*%h got %h want %h", s, m, got, q8[0]);
            end
            if (q8.size() != 0) void'(q8.pop_front());
            checks++;
            if (cyc != 17) begin
                errors++;
                $display("FAIL signed_latency: Done at cycle %0d want 17", cyc);
            end
            @(negedge clk);
            checks++;
            if (done8 !== 1'b0 || prod8 !== got || busy8 !== 1'b0) begin
                errors++;
                $display("FAIL signed_hold: done=%b busy=%b prod=%h want 0 0 %h", done8, busy8, prod8, got);
            end
        end
    endtask

    task automatic test_unsigned;
        logic [7:0]  ts[5];
        logic [7:0]  tm[5];
        logic [15:0] tp[5];
        logic [63:0] r;
        logic [15:0] got, exp_p;
        int cyc;
        ts[0] = 8'hFF; tm[0] = 8'hFF; tp[0] = 16'hFE01;
        ts[1] = 8'h00; tm[1] = 8'hA5; tp[1] = 16'h0000;
        ts[2] = 8'h03; tm[2] = 8'h05; tp[2] = 16'h000F;
        ts[3] = 8'h80; tm[3] = 8'h80; tp[3] = 16'h4000;
        ts[4] = 8'hC8; tm[4] = 8'h02; tp[4] = 16'h0190;
        for (int i = 0; i < 25; i++) begin
            logic [7:0] s, m;
            if (i < 5) begin
                s = ts[i]; m = tm[i]; exp_p = tp[i];
            end else begin
                s = 8'($urandom); m = 8'($urandom);
                r = ref_mul({24'h0, s}, {24'h0, m}, 8, 1'b0);
                exp_p = r[15:0];
            end
            do_op8(s, m, 1'b0, exp_p, cyc, got);
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL unsigned_sb: scoreboard empty at op %0d", i);
            end else if (got !== q8[0]) begin
                errors++;
                $display("FAIL unsigned_prod: %h*%h got %h want %h", s, m, got, q8[0]);
            end
            if (q8.size() != 0) void'(q8.pop_front());
            checks++;
            if (cyc != 17 || x8 !== 1'b0) begin
                errors++;
                $display("FAIL unsigned_latency: Done cycle %0d Xval %b want 17 0", cyc, x8);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int cyc, ndone, done_cyc;
        logic [15:0] got;
        got = 16'h0; ndone = 0; done_cyc = 0;
        @(negedge clk);
        s8 = 8'h7F; m8 = 8'h81; sgn8 = 1'b1; start8 = 1'b1;
        q8.push_back(16'hC0FF);
        @(posedge clk);
        cyc = 1;
        while (cyc <= 25) begin
            @(negedge clk);
            start8 = (cyc == 3);
            if (cyc == 3) begin
                checks++;
                if (busy8 !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_high: busy=%b want 1", busy8);
                end
            end
            if (cyc == 5) begin
                s8 = 8'h12; m8 = 8'h34; sgn8 = 1'b0;
            end
            if (done8 === 1'b1) begin
                ndone++;
                done_cyc = cyc;
                got = prod8;
            end
            @(posedge clk);
            cyc++;
        end
        start8 = 1'b0;
        checks++;
        if (ndone != 1 || done_cyc != 17) begin
            errors++;
            $display("FAIL busy_done: %0d pulses last at cycle %0d, want 1 at 17", ndone, done_cyc);
        end
        checks++;
        if (q8.size() == 0 || got !== q8[0]) begin
            errors++;
            $display("FAIL busy_prod: got %h want c0ff", got);
        end
        if (q8.size() != 0) void'(q8.pop_front());
    endtask

    task automatic test_reset_abort;
        int cyc, ndone;
        logic [15:0] got;
        @(negedge clk);
        s8 = 8'hFF; m8 = 8'hFF; sgn8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b1 || prod8 === 16'h0000) begin
            errors++;
            $display("FAIL abort_pre: busy=%b prod=%h want 1 and nonzero", busy8, prod8);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy8 !== 1'b0 || prod8 !== 16'h0000 || done8 !== 1'b0 || x8 !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b prod=%h done=%b x=%b want 0 0000 0 0", busy8, prod8, done8, x8);
        end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL abort_quiet: %0d active cycles after reset, want 0", ndone);
        end
        do_op8(8'h03, 8'h05, 1'b0, 16'h000F, cyc, got);
        checks++;
        if (q8.size() == 0 || got !== q8[0] || cyc != 17) begin
            errors++;
            $display("FAIL abort_next: prod %h cycle %0d want 000f 17", got, cyc);
        end
        if (q8.size() != 0) void'(q8.pop_front());
    endtask

    task automatic test_back_to_back16;
        logic [63:0] r;
        int cyc;
        bit sgn;
        bit abort;
        abort = 1'b0;
        @(negedge clk);
        s16 = 16'h8000; m16 = 16'h8000; sgn16 = 1'b1; start16 = 1'b1;
        for (int i = 0; i < 2000 && !abort; i++) begin
            r = ref_mul({16'h0, s16}, {16'h0, m16}, 16, sgn16);
            q16.push_back(r[31:0]);
            cyc = 0;
            do begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end while (done16 !== 1'b1 && cyc < 60);
            checks++;
            if (done16 !== 1'b1 || cyc != 33) begin
                errors++;
                $display("FAIL b2b_latency: op %0d Done=%b at cycle %0d want 33", i, done16, cyc);
                abort = (done16 !== 1'b1);
            end
            checks++;
            if (prod16 !== q16[0]) begin
                errors++;
                $display("FAIL b2b_prod: op %0d mode %b %h*%h got %h want %h",
                         i, sgn16, s16, m16, prod16, q16[0]);
            end
            void'(q16.pop_front());
            if (i == 1999) begin
                start16 = 1'b0;
            end else begin
                sgn  = (i % 2 == 0) ? 1'b0 : 1'b1;
                sgn16 = sgn;
                s16 = (i == 0) ? 16'hFFFF : 16'($urandom);
                m16 = (i == 0) ? 16'hFFFF : 16'($urandom);
            end
            @(negedge clk);
            checks++;
            if (busy16 !== 1'b0 || done16 !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle: busy=%b done=%b want 0 0", busy16, done16);
            end
        end
        start16 = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        start8 = 1'b0; sgn8 = 1'b0; s8 = 8'h0; m8 = 8'h0;
        start16 = 1'b0; sgn16 = 1'b0; s16 = 16'h0; m16 = 16'h0;
        test_reset;
        test_signed;
        test_unsigned;
        test_busy_ignore;
        test_reset_abort;
        test_back_to_back16;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
